sram_like_arbiter: RTL and testbench

- Shares one SRAM-like memory port between two requesters: the instruction-fetch requester (IF stage) and the data requester (EXE issue / MEM return).
- Uses the split address/data handshake req / addr_ok / data_ok.
- Returns read data and write acknowledgements to the correct requester in issue order.
- Sits between the pipeline stages and the memory bridge.

---
 rtl/sram_like_arbiter_pkg.sv | 32 +++
 rtl/sram_like_arbiter_owner_fifo.sv | 70 +++++++
 rtl/sram_like_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_like_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// ============================================================================
// Module   : sram_like_arbiter_pkg
// Brief    : Shared owner codes, size encodings and request payload type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_like_arbiter_pkg;

  // Payload widths; the arbiter's ADDR_W/DATA_W must not exceed these.
  localparam int PL_ADDR_W = 32;
  localparam int PL_DATA_W = 32;
  localparam int PL_STRB_W = PL_DATA_W / 8;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic                 wr;
    logic [1:0]           size;
    logic [PL_ADDR_W-1:0] addr;
    logic [PL_STRB_W-1:0] wstrb;
    logic [PL_DATA_W-1:0] wdata;
  } req_payload_t;

endpackage

`default_nettype wire

// File: rtl/sram_like_arbiter_owner_fifo.sv
// ============================================================================
// Module   : owner_fifo
// Brief    : Small synchronous FIFO recording the owner of each accepted request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module owner_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
// ============================================================================
// Module   : sram_like_arbiter
// Brief    : Shares one SRAM-like port between inst and data requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W     = PL_ADDR_W,
  parameter int DATA_W     = PL_DATA_W,
  parameter int MAX_OUTST  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_spurious
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic            r_lock;
  logic            r_lock_owner;
  logic [SC_W-1:0] r_starve_cnt;
  logic            r_err_spurious;
  logic            w_grant;
  logic            w_gnt_req;
  logic            w_push;
  logic            w_resp_valid;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_head;
  req_payload_t    w_inst_pl;
  req_payload_t    w_data_pl;
  req_payload_t    w_sel_pl;

  always_comb begin
    w_inst_pl.wr    = inst_wr;
    w_inst_pl.size  = inst_size;
    w_inst_pl.addr  = PL_ADDR_W'(inst_addr);
    w_inst_pl.wstrb = PL_STRB_W'(inst_wstrb);
    w_inst_pl.wdata = PL_DATA_W'(inst_wdata);
    w_data_pl.wr    = data_wr;
    w_data_pl.size  = data_size;
    w_data_pl.addr  = PL_ADDR_W'(data_addr);
    w_data_pl.wstrb = PL_STRB_W'(data_wstrb);
    w_data_pl.wdata = PL_DATA_W'(data_wdata);
  end

  // A pending unaccepted request pins the grant so the payload stays stable.
  always_comb begin
    w_grant = OWNER_DATA;
    if (r_lock) begin
      w_grant = r_lock_owner;
    end else if (inst_req && data_req) begin
      w_grant = (r_starve_cnt == SC_W'(STARVE_MAX)) ? OWNER_INST : OWNER_DATA;
    end else if (inst_req) begin
      w_grant = OWNER_INST;
    end
  end

  assign w_gnt_req = (w_grant == OWNER_DATA) ? data_req : inst_req;
  assign w_sel_pl  = (w_grant == OWNER_DATA) ? w_data_pl : w_inst_pl;

  assign mem_req   = w_gnt_req && !w_fifo_full && !reset;
  assign mem_wr    = w_sel_pl.wr;
  assign mem_size  = w_sel_pl.size;
  assign mem_addr  = ADDR_W'(w_sel_pl.addr);
  assign mem_wstrb = (DATA_W/8)'(w_sel_pl.wstrb);
  assign mem_wdata = DATA_W'(w_sel_pl.wdata);

  assign w_push       = mem_req && mem_addr_ok;
  assign inst_addr_ok = w_push && (w_grant == OWNER_INST);
  assign data_addr_ok = w_push && (w_grant == OWNER_DATA);

  assign w_resp_valid = mem_data_ok && !w_fifo_empty && !reset;
  assign inst_data_ok = w_resp_valid && (w_head == OWNER_INST);
  assign data_data_ok = w_resp_valid && (w_head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err_spurious = r_err_spurious;

  owner_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (1)
  ) u_owner_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_grant),
    .pop       (w_resp_valid),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .head      (w_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock         <= 1'b0;
      r_lock_owner   <= OWNER_INST;
      r_starve_cnt   <= '0;
      r_err_spurious <= 1'b0;
    end else begin
      if (mem_req && !mem_addr_ok) begin
        r_lock       <= 1'b1;
        r_lock_owner <= w_grant;
      end else if (mem_addr_ok) begin
        r_lock <= 1'b0;
      end
      if (!inst_req || inst_addr_ok) begin
        r_starve_cnt <= '0;
      end else if (data_addr_ok && (r_starve_cnt != SC_W'(STARVE_MAX))) begin
        r_starve_cnt <= r_starve_cnt + SC_W'(1);
      end
      if (mem_data_ok && w_fifo_empty) begin
        r_err_spurious <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
// ============================================================================
// Module   : tb_sram_like_arbiter
// Brief    : Directed scoreboard bench for the shared SRAM-like port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic [3:0]  inst_wstrb;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        err_spurious;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  logic exp_data;

  sram_like_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUTST(2), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic owner, input logic [31:0] rdata);
    exp_t e;
    e.owner = owner;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = SIZE_WORD; inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = SIZE_WORD; data_addr = '0; data_wstrb = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  // Monitor: every response is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && (inst_data_ok || data_data_ok)) begin
      if (inst_data_ok && data_data_ok) begin
        checks++; failures++;
        $display("FAIL both_data_ok actual=both required=one");
      end else if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_data_ok actual=inst:%0d data:%0d required=none", inst_data_ok, data_data_ok);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_owner", 64'(data_data_ok), 64'(mon_e.owner));
        chk("resp_rdata", data_data_ok ? data_rdata : inst_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    idle();
    reset = 1; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    samp();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    cyc(); cyc();
    reset = 0; idle();
    samp();
    chk("rst_err_spurious", err_spurious, 0);
    chk("idle_mem_req", mem_req, 0);
    cyc();

    // Single inst read
    inst_req = 1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1;
    samp();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h1c00_0000);
    chk("t1_inst_addr_ok", inst_addr_ok, 1);
    chk("t1_data_addr_ok", data_addr_ok, 0);
    push_exp(OWNER_INST, 32'hDEAD_BEEF);
    cyc(); idle();
    cyc(); mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
    samp();
    chk("t1_inst_data_ok", inst_data_ok, 1);
    chk("t1_data_data_ok", data_data_ok, 0);
    cyc(); idle();

    // Simultaneous requests: data first, then inst
    inst_req = 1; inst_addr = 32'h1c00_0004;
    data_req = 1; data_addr = 32'h8000_0010; data_wr = 1; data_wstrb = 4'hf; data_wdata = 32'h1122_3344;
    mem_addr_ok = 1;
    samp();
    chk("t2_data_addr_ok", data_addr_ok, 1);
    chk("t2_inst_addr_ok", inst_addr_ok, 0);
    chk("t2_mem_addr", mem_addr, 32'h8000_0010);
    chk("t2_mem_wr", mem_wr, 1);
    chk("t2_mem_wdata", mem_wdata, 32'h1122_3344);
    chk("t2_mem_wstrb", mem_wstrb, 4'hf);
    push_exp(OWNER_DATA, 32'hAAAA_0001);
    cyc(); data_req = 0;
    samp();
    chk("t2_inst_second", inst_addr_ok, 1);
    chk("t2_mem_addr_inst", mem_addr, 32'h1c00_0004);
    chk("t2_mem_wr_inst", mem_wr, 0);
    push_exp(OWNER_INST, 32'hBBBB_0002);
    cyc(); idle(); mem_data_ok = 1; mem_rdata = 32'hAAAA_0001;
    cyc(); mem_rdata = 32'hBBBB_0002;
    cyc(); idle();

    // Hold: data waits three cycles, inst arrives meanwhile
    for (int k = 0; k < 4; k++) begin
      data_req = 1; data_addr = 32'h8000_0020; data_wr = 1; data_wstrb = 4'h3; data_wdata = 32'h0000_5a5a;
      inst_req = (k > 0); inst_addr = 32'h1c00_0008;
      mem_addr_ok = (k == 3);
      samp();
      chk($sformatf("t3_mem_addr_%0d", k), mem_addr, 32'h8000_0020);
      chk($sformatf("t3_data_addr_ok_%0d", k), data_addr_ok, (k == 3));
      chk($sformatf("t3_inst_addr_ok_%0d", k), inst_addr_ok, 0);
      cyc();
    end
    push_exp(OWNER_DATA, 32'h0000_C0C0);
    data_req = 0;
    samp();
    chk("t3_inst_after", inst_addr_ok, 1);
    push_exp(OWNER_INST, 32'h0000_D0D0);
    cyc(); idle(); mem_data_ok = 1; mem_rdata = 32'h0000_C0C0;
    cyc(); mem_rdata = 32'h0000_D0D0;
    cyc(); idle();

    // Lock keeps a stalled inst request granted when data arrives
    inst_req = 1; inst_addr = 32'h1c00_0040;
    samp();
    chk("t3b_mem_addr_0", mem_addr, 32'h1c00_0040);
    cyc(); data_req = 1; data_addr = 32'h8000_0040;
    samp();
    chk("t3b_mem_addr_1", mem_addr, 32'h1c00_0040);
    cyc(); mem_addr_ok = 1;
    samp();
    chk("t3b_inst_addr_ok", inst_addr_ok, 1);
    chk("t3b_data_addr_ok", data_addr_ok, 0);
    push_exp(OWNER_INST, 32'h0000_E0E0);
    cyc(); inst_req = 0;
    samp();
    chk("t3b_data_after", data_addr_ok, 1);
    push_exp(OWNER_DATA, 32'h0000_F0F0);
    cyc(); idle(); mem_data_ok = 1; mem_rdata = 32'h0000_E0E0;
    cyc(); mem_rdata = 32'h0000_F0F0;
    cyc(); idle();

    // Full owner FIFO blocks a third request, even during a pop
    for (int k = 0; k < 2; k++) begin
      data_req = 1; data_addr = 32'h8000_0030 + 32'(4 * k); mem_addr_ok = 1;
      samp();
      chk($sformatf("t4_accept_%0d", k), data_addr_ok, 1);
      push_exp(OWNER_DATA, 32'h6000_0000 + 32'(k));
      cyc();
    end
    data_addr = 32'h8000_0038;
    samp();
    chk("t4_full_mem_req", mem_req, 0);
    chk("t4_full_addr_ok", data_addr_ok, 0);
    cyc(); mem_data_ok = 1; mem_rdata = 32'h6000_0000;
    samp();
    chk("t4_full_pop_mem_req", mem_req, 0);
    cyc(); mem_data_ok = 0;
    samp();
    chk("t4_third_mem_req", mem_req, 1);
    chk("t4_third_accept", data_addr_ok, 1);
    push_exp(OWNER_DATA, 32'h6000_0002);
    cyc(); data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h6000_0001;
    cyc(); mem_rdata = 32'h6000_0002;
    cyc(); idle();

    // Starvation: data x4, inst x1, repeating
    for (int k = 0; k < 10; k++) begin
      inst_req = 1; inst_addr = 32'h1c00_0100;
      data_req = 1; data_addr = 32'h8000_0100; mem_addr_ok = 1;
      mem_data_ok = (k > 0); mem_rdata = 32'h5000_0000 + 32'(k) - 32'd1;
      samp();
      exp_data = ((k % 5) != 4);
      chk($sformatf("t5_data_acc_%0d", k), data_addr_ok, exp_data);
      chk($sformatf("t5_inst_acc_%0d", k), inst_addr_ok, !exp_data);
      push_exp(exp_data ? OWNER_DATA : OWNER_INST, 32'h5000_0000 + 32'(k));
      cyc();
    end
    idle(); mem_data_ok = 1; mem_rdata = 32'h5000_0009;
    cyc(); idle();

    // Spurious response with empty FIFO
    mem_data_ok = 1; mem_rdata = 32'h0bad_0bad;
    samp();
    chk("t6_spur_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("t6_err_before", err_spurious, 0);
    cyc(); idle();
    samp();
    chk("t6_err_set", err_spurious, 1);
    cyc(); cyc();
    samp();
    chk("t6_err_sticky", err_spurious, 1);

    // Reset with two outstanding transactions
    cyc(); data_req = 1; data_addr = 32'h8000_0200; mem_addr_ok = 1;
    cyc(); cyc();
    reset = 1; mem_data_ok = 1;
    samp();
    chk("t6_rst_mem_req", mem_req, 0);
    chk("t6_rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    chk("t6_rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    cyc(); reset = 0; idle();
    samp();
    chk("t6_post_rst_err", err_spurious, 0);
    cyc(); mem_data_ok = 1;
    samp();
    chk("t6_post_rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    cyc(); idle();
    samp();
    chk("t6_post_rst_err_set", err_spurious, 1);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
